// File: rtl/pc_sequencer.sv
// pc_sequencer: run/halt sequencer driving PC branch/jcnd/target from a software-loaded target table.
// Define PC_SEQ_RAS_EN to build the CALL/RET return-address stack; otherwise CALL acts as JMP and RET as NOP.
module pc_sequencer #(
    parameter int D         = 12,
    parameter int LUT_DEPTH = 16,
    parameter int RAS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [2:0]                   op,
    input  logic [$clog2(LUT_DEPTH)-1:0] lut_idx,
    input  logic                         flag,
    input  logic [D-1:0]                 prog_ctr_i,
    input  logic                         cfg_we,
    input  logic [$clog2(LUT_DEPTH)-1:0] cfg_addr,
    input  logic [D-1:0]                 cfg_data,
    output logic                         pc_reset,
    output logic [1:0]                   branch,
    output logic                         jcnd,
    output logic [D-1:0]                 target,
    output logic                         running,
    output logic                         done,
    output logic [15:0]                  cycles,
    output logic                         ras_err
);
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
    state_t state;
    logic [D-1:0] lut [LUT_DEPTH];
    logic [D-1:0] lut_t;
    logic [D-1:0] ras_top;
    logic ret_ok;
    logic in_run;
    assign lut_t  = lut[lut_idx];
    assign in_run = state == RUN;
`ifdef PC_SEQ_RAS_EN
    localparam int SW = $clog2(RAS_DEPTH) + 1;
    logic [D-1:0] ras [RAS_DEPTH];
    logic [SW-1:0] sp, sp_m1;
    logic ras_full;
    assign sp_m1    = sp - SW'(1);
    assign ras_full = sp == SW'(RAS_DEPTH);
    assign ret_ok   = sp != '0;
    assign ras_top  = ret_ok ? ras[sp_m1[SW-2:0]] : '0;
    // Stack empties at reset and whenever a halted program is rearmed.
    always_ff @(posedge clk) begin
        if (reset || (state == HALT && start)) begin
            sp      <= '0;
            ras_err <= 1'b0;
        end else if (in_run && op == 3'd4) begin
            if (ras_full) ras_err <= 1'b1;
            else begin
                ras[sp[SW-2:0]] <= prog_ctr_i + D'(1);
                sp              <= sp + SW'(1);
            end
        end else if (in_run && op == 3'd5) begin
            if (!ret_ok) ras_err <= 1'b1;
            else sp <= sp_m1;
        end
    end
`else
    assign ret_ok  = 1'b0;
    assign ras_top = '0;
    assign ras_err = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LUT_DEPTH; i++) lut[i] <= '0;
        end else if (state == IDLE && cfg_we) begin
            lut[cfg_addr] <= cfg_data;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            pc_reset <= 1'b1;
            running  <= 1'b0;
            done     <= 1'b0;
            cycles   <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state    <= RUN;
                    pc_reset <= 1'b0;
                    running  <= 1'b1;
                    cycles   <= '0;
                end
                RUN: begin
                    cycles <= (cycles == 16'hFFFF) ? cycles : cycles + 16'd1;
                    if (op == 3'd6) begin
                        state   <= HALT;
                        running <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                HALT: if (start) begin
                    state    <= IDLE;
                    pc_reset <= 1'b1;
                    done     <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
    always_comb begin
        branch = 2'b00;
        jcnd   = 1'b0;
        target = '0;
        if (state == HALT) begin
            branch = 2'b11;
            target = prog_ctr_i;
        end else if (in_run) begin
            case (op)
                3'd1, 3'd4: begin branch = 2'b11; target = lut_t; end
                3'd2: begin branch = 2'b01; jcnd = flag; target = lut_t; end
                3'd3: begin branch = 2'b10; jcnd = flag; target = lut_t; end
                3'd5: begin branch = ret_ok ? 2'b11 : 2'b00; target = ras_top; end
                3'd6: begin branch = 2'b11; target = prog_ctr_i; end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: drives pc_sequencer against a behavioural PC; expected next-PC values go through a scoreboard queue.
module tb_pc_sequencer;
    localparam int D = 12;
`ifdef PC_SEQ_RAS_EN
    localparam logic [D-1:0] PH = 12'h042;
    localparam logic RAS = 1'b1;
`else
    localparam logic [D-1:0] PH = 12'h102;
    localparam logic RAS = 1'b0;
`endif
    logic clk = 0, reset = 1, start = 0, flag = 0, cfg_we = 0;
    logic [2:0] op = 0;
    logic [3:0] lut_idx = 0, cfg_addr = 0;
    logic [D-1:0] cfg_data = 0, pc, target;
    logic pc_reset, jcnd, running, done, ras_err;
    logic [1:0] branch;
    logic [15:0] cycles;
    int checks = 0, failures = 0;
    logic [D-1:0] exp_q [$];

    pc_sequencer #(.D(D), .LUT_DEPTH(16), .RAS_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .lut_idx(lut_idx),
        .flag(flag), .prog_ctr_i(pc), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .pc_reset(pc_reset), .branch(branch), .jcnd(jcnd),
        .target(target), .running(running), .done(done), .cycles(cycles),
        .ras_err(ras_err)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk)
        pc <= pc_reset ? '0 :
              (branch == 2'b11 || (branch == 2'b01 && jcnd) || (branch == 2'b10 && !jcnd)) ? target :
              pc + 12'd1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic cyc(input string tag, input logic [2:0] o, input logic [3:0] i, input logic f,
                       input logic [1:0] wb, input logic wj, input logic [D-1:0] nxt);
        @(negedge clk);
        op = o; lut_idx = i; flag = f;
        exp_q.push_back(nxt);
        #1;
        check({tag, "_branch"}, branch, wb);
        check({tag, "_jcnd"}, jcnd, wj);
        @(posedge clk); #1;
        if (exp_q.size() == 0) check({tag, "_sb_empty"}, 1, 0);
        else check({tag, "_pc"}, pc, exp_q.pop_front());
    endtask

    task automatic wr(input logic [3:0] a, input logic [D-1:0] d, input logic st);
        @(negedge clk);
        cfg_we = 1; cfg_addr = a; cfg_data = d; start = st; op = 0;
        @(posedge clk); #1;
        cfg_we = 0; start = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1; op = 0;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic rst_chk(input string tag);
        check({tag, "_pc_reset"}, pc_reset, 1);
        check({tag, "_running"}, running, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_cycles"}, cycles, 0);
        check({tag, "_ras_err"}, ras_err, 0);
        check({tag, "_branch"}, branch, 0);
        check({tag, "_target"}, target, 0);
        check({tag, "_jcnd"}, jcnd, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 0;
        rst_chk("rst");
        wr(3, 12'h040, 0);
        wr(1, 12'h010, 0);
        wr(5, 12'h200, 0);
        wr(2, 12'h100, 1);
        check("run1_running", running, 1);
        check("run1_pcr", pc_reset, 0);
        check("run1_pc0", pc, 0);
        for (int k = 0; k < 5; k++) cyc("nop", 0, 0, 0, 2'b00, 0, D'(k + 1));
        cyc("bt1", 2, 1, 1, 2'b01, 1, 12'h010);
        cyc("bt0", 2, 1, 0, 2'b01, 0, 12'h011);
        cyc("bf0", 3, 1, 0, 2'b10, 0, 12'h010);
        cyc("bf1", 3, 1, 1, 2'b10, 1, 12'h011);
        cyc("jmp", 1, 3, 0, 2'b11, 0, 12'h040);
        cyc("call", 4, 2, 0, 2'b11, 0, 12'h100);
        if (RAS) begin
            cyc("ret", 5, 0, 0, 2'b11, 0, 12'h041);
            check("ret_err", ras_err, 0);
            cyc("ret_empty", 5, 0, 0, 2'b00, 0, 12'h042);
            check("ret_empty_err", ras_err, 1);
        end else begin
            cyc("ret", 5, 0, 0, 2'b00, 0, 12'h101);
            cyc("ret_empty", 5, 0, 0, 2'b00, 0, 12'h102);
            check("ret_empty_err", ras_err, 0);
        end
        cyc("halt1", 6, 0, 0, 2'b11, 0, PH);
        check("halt1_done", done, 1);
        check("halt1_running", running, 0);
        check("halt1_cycles", cycles, 14);
        op = 0;
        repeat (3) begin
            @(posedge clk); #1;
            check("halt1_hold_pc", pc, PH);
            check("halt1_hold_branch", branch, 2'b11);
        end
        pulse_start();
        check("rearm_pcr", pc_reset, 1);
        check("rearm_done", done, 0);
        check("rearm_ras_err", ras_err, 0);
        pulse_start();
        check("run2_pc0", pc, 0);
        for (int k = 0; k < 7; k++) cyc("nop2", 0, 0, 0, 2'b00, 0, D'(k + 1));
        cyc("halt2", 6, 0, 0, 2'b11, 0, 12'h007);
        check("halt2_done", done, 1);
        check("halt2_cycles", cycles, 8);
        start = 1;
        #1;
        check("halt2_start_comb", branch, 2'b11);
        start = 0;
        repeat (10) begin
            @(posedge clk); #1;
            check("halt2_hold_pc", pc, 12'h007);
            check("halt2_hold_cycles", cycles, 8);
        end
        pulse_start();
        check("idle_pcr", pc_reset, 1);
        pulse_start();
        check("run3_cycles_clr", cycles, 0);
        cyc("call0", 4, 5, 0, 2'b11, 0, 12'h200);
        for (int k = 1; k < 5; k++) begin
            cyc("calln", 4, 5, 0, 2'b11, 0, 12'h200);
            check("calln_err", ras_err, (k == 4) ? RAS : 1'b0);
        end
        cfg_we = 1; cfg_addr = 3; cfg_data = 12'hABC;
        cyc("cfg_run", 0, 0, 0, 2'b00, 0, 12'h201);
        cfg_we = 0;
        cyc("lockout", 1, 3, 0, 2'b11, 0, 12'h040);
        @(negedge clk);
        op = 0; reset = 1;
        @(posedge clk); #1;
        reset = 0;
        rst_chk("midrst");
        pulse_start();
        check("run4_pc0", pc, 0);
        cyc("lut_clr", 1, 3, 0, 2'b11, 0, 12'h000);
        check("run4_cycles", cycles, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
